seq_mul_sd: RTL and testbench

- Parametrised sequential shift-add multiplier. Successor to the 3-bit combinational array multiplier.
- Trades area for latency: one partial product per clock.
- Adds a start/busy/done handshake and a per-operation signed (two's complement) or unsigned mode.
- Sits as an arithmetic slave under a controller that issues one multiply at a time.

---
 rtl/mul_pkg.sv | 28 ++
 rtl/seq_mul_dp.sv | 51 +++++
 rtl/seq_mul_sd.sv | 118 +++++++++++
 tb/tb_seq_mul_sd.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e : controller state (IDLE, RUN, FIX, DONE), 2-bit encoding
//   abs_w   : magnitude of a width-bit operand, two's complement only when
//             signed_mode is set; raw bits otherwise
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // value holds the operand zero-extended to 32 bits; width is 2..32.
  // The caller truncates the result back to width bits, so the most
  // negative value maps to 2^(width-1) without overflow.
  function automatic logic [31:0] abs_w(input logic [31:0] value,
                                        input int unsigned width,
                                        input logic        signed_mode);
    logic [31:0] mag;
    mag = value;
    if (signed_mode && value[5'(width - 1)]) begin
      mag = ~value + 32'd1;
    end
    return mag;
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// Datapath of the sequential multiplier: operand registers, multiplier
// shift register and the (2*WIDTH+1)-bit accumulator with its adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture magnitudes, clear accumulator
//   step_i     : perform one shift-add iteration
//   a_mag_i    : |a| (WIDTH bits, unsigned)
//   b_mag_i    : |b| (WIDTH bits, unsigned)
//   acc_o      : accumulator; after WIDTH steps bits [2W-1:0] hold |a|*|b|
module seq_mul_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  output logic [2*WIDTH:0]   acc_o
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_d;
  logic [2*WIDTH:0] sum;

  // Partial product enters the upper half; the extra top bit absorbs the
  // carry so the right shift never loses it.
  always_comb begin
    sum   = acc_q + (b_q[0] ? {1'b0, a_q, {WIDTH{1'b0}}} : '0);
    acc_d = sum >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      a_q   <= a_mag_i;
      b_q   <= b_mag_i;
      acc_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      b_q   <= b_q >> 1;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/seq_mul_sd.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, accepted only in IDLE or DONE
//   signed_mode  : 1 = a, b, prod two's complement; sampled with start
//   a, b         : WIDTH-bit operands, sampled with start
//   busy         : high while RUN or FIX
//   done         : one-cycle pulse, prod valid from this cycle
//   prod         : 2*WIDTH-bit result, held until the next done
//   dbg_state    : current controller state
//
// Handshake: start is sampled on a rising edge only when busy=0; the
// operation then runs WIDTH+1 clocks with busy=1, ignoring start and the
// operand inputs, and completes with a single-cycle done. start held high
// during the done cycle launches the next operation back-to-back.
module seq_mul_sd
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod,
  output state_e               dbg_state
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q;
  logic               done_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               load;
  logic               step;
  logic               fix;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH:0]   acc;

  assign a_mag = WIDTH'(abs_w(32'(a), WIDTH, signed_mode));
  assign b_mag = WIDTH'(abs_w(32'(b), WIDTH, signed_mode));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q counts iterations already done; this edge is the last one.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        fix     = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= fix;
      if (load) begin
        neg_q <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end
      if (fix) begin
        // Magnitude product always fits in 2*WIDTH bits, so the sign fix
        // is a plain negate and truncation.
        prod_q <= (2*WIDTH)'(neg_q ? -acc : acc);
      end
    end
  end

  seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .step_i  (step),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .acc_o   (acc)
  );

  assign busy      = (state_q == RUN) || (state_q == FIX);
  assign done      = done_q;
  assign prod      = prod_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mul_sd.sv
module tb_seq_mul_sd;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT, WIDTH=8 ----------------
  logic             start8, sm8;
  logic [7:0]       a8, b8;
  logic             busy8, done8;
  logic [15:0]      prod8;
  mul_pkg::state_e  st8;

  seq_mul_sd #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .prod(prod8),
    .dbg_state(st8)
  );

  // ---------------- DUT, WIDTH=3 ----------------
  logic             start3, sm3;
  logic [2:0]       a3, b3;
  logic             busy3, done3;
  logic [5:0]       prod3;
  mul_pkg::state_e  st3;

  seq_mul_sd #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .signed_mode(sm3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .prod(prod3),
    .dbg_state(st3)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer product of the operands as interpreted by the mode,
  // reduced to 2*w bits.
  function automatic logic [63:0] model(input int w, input logic sm,
                                        input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, p;
    sa = longint'(av);
    sb = longint'(bv);
    if (sm && (((av >> (w - 1)) & 32'd1) != 0)) sa = sa - (longint'(1) << w);
    if (sm && (((bv >> (w - 1)) & 32'd1) != 0)) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic op3(input logic [2:0] av, input logic [2:0] bv);
    int lat;
    @(negedge clk);
    start3 = 1'b1; a3 = av; b3 = bv;
    exp_q.push_back(model(3, 1'b0, 32'(av), 32'(bv)));
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat3", 64'(lat), 64'd4);
    check("prod3", 64'(prod3), exp_q.pop_front());
  endtask

  task automatic op8(input logic sm, input logic [7:0] av, input logic [7:0] bv);
    int lat;
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; a8 = av; b8 = bv;
    exp_q.push_back(model(8, sm, 32'(av), 32'(bv)));
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat8", 64'(lat), 64'd9);
    check("prod8", 64'(prod8), exp_q.pop_front());
  endtask

  // ---------------- per-edge monitors ----------------
  int   run8 = 0, run3 = 0;
  logic prev_done8 = 1'b0, prev_done3 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run8 = 0; run3 = 0;
      prev_done8 = 1'b0; prev_done3 = 1'b0;
    end else begin
      if (busy8) run8++;
      else if (run8 != 0) begin
        check("busy_len8", 64'(run8), 64'd9);
        run8 = 0;
      end
      if (busy3) run3++;
      else if (run3 != 0) begin
        check("busy_len3", 64'(run3), 64'd4);
        run3 = 0;
      end
      if (done8) check("done_pulse8", 64'(prev_done8), 64'd0);
      if (done3) check("done_pulse3", 64'(prev_done3), 64'd0);
      prev_done8 = done8;
      prev_done3 = done3;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  logic [63:0] exp1, exp2;
  int          gap, ndone;

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; sm3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", 64'(prod8), 64'd0);
    check("rst_state8", 64'(st8), 64'(mul_pkg::IDLE));
    check("rst_busy3", 64'(busy3), 64'd0);
    check("rst_done3", 64'(done3), 64'd0);
    check("rst_prod3", 64'(prod3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=3 unsigned, every operand pair
    for (int i = 0; i < 64; i++) op3(3'(i >> 3), 3'(i));

    // WIDTH=8 corner cases
    op8(1'b1, 8'h80, 8'h80);
    op8(1'b1, 8'h80, 8'h7f);
    op8(1'b1, 8'hff, 8'h01);
    op8(1'b0, 8'hff, 8'hff);
    op8(1'b1, 8'h00, 8'h85);
    op8(1'b0, 8'h80, 8'h02);
    op8(1'b1, 8'h7f, 8'h7f);

    // WIDTH=8 random
    repeat (40) op8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));

    // Back-to-back: start held high, next operands presented in the done cycle
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'hf3; b8 = 8'h25;
    exp1 = model(8, 1'b1, 32'h0000_00f3, 32'h0000_0025);
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22;
    gap = 0;
    while (!done8 && gap < 30) begin
      @(posedge clk); #1;
      gap++;
    end
    check("b2b_lat1", 64'(gap), 64'd9);
    check("b2b_prod1", 64'(prod8), exp1);
    sm8 = 1'b0; a8 = 8'hc8; b8 = 8'h0b;
    exp2 = model(8, 1'b0, 32'h0000_00c8, 32'h0000_000b);
    @(posedge clk); #1;
    start8 = 1'b0;
    gap = 1;
    while (!done8 && gap < 30) begin
      check("b2b_hold", 64'(prod8), exp1);
      @(posedge clk); #1;
      gap++;
    end
    check("b2b_gap", 64'(gap), 64'd10);
    check("b2b_prod2", 64'(prod8), exp2);

    // start with new operands during RUN is ignored
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'h5a; b8 = 8'h3c;
    exp1 = model(8, 1'b0, 32'h0000_005a, 32'h0000_003c);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'hff; b8 = 8'h81;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_prod", 64'(prod8), exp1);

    // Asynchronous reset three clocks into RUN
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'h9c; b8 = 8'h47;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy8", 64'(busy8), 64'd0);
    check("arst_done8", 64'(done8), 64'd0);
    check("arst_prod8", 64'(prod8), 64'd0);
    check("arst_state8", 64'(st8), 64'(mul_pkg::IDLE));
    check("arst_prod3", 64'(prod3), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);
    op8(1'b1, 8'h9c, 8'h47);
    op8(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    op3(3'd7, 3'd7);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
